mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 28 ++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared defaults, FSM state type and requester indices for the data-memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned NREQ_DEF = 3;
  localparam int unsigned AW_DEF   = 12;
  localparam int unsigned DW_DEF   = 32;

  localparam int unsigned REQ_CORE  = 0;
  localparam int unsigned REQ_UART  = 1;
  localparam int unsigned REQ_DEBUG = 2;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StRdata
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index after last_grant, wrapping modulo NREQ.
module rr_pick #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] eligible_i,
  input  logic [IW-1:0]   last_grant_i,
  output logic            valid_o,
  output logic [IW-1:0]   index_o
);

  int unsigned w_c;

  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    w_c     = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_c = 32'(last_grant_i) + k;
      if (w_c >= NREQ) w_c = w_c - NREQ;
      if (!valid_o && eligible_i[w_c[IW-1:0]]) begin
        valid_o = 1'b1;
        index_o = w_c[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port data-memory arbiter: round-robin among requesters, one command per ACCESS cycle,
// read data returned in the following RDATA cycle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned DW   = DW_DEF
) (
  input  logic                      clk,
  input  logic                      Rst,
  input  logic                      prog,
  input  logic [NREQ-1:0]           req_i,
  input  logic [NREQ-1:0]           we_i,
  input  logic [NREQ-1:0][3:0]      be_i,
  input  logic [NREQ-1:0][AW-1:0]   addr_i,
  input  logic [NREQ-1:0][DW-1:0]   wdata_i,
  output logic [NREQ-1:0]           gnt_o,
  output logic [NREQ-1:0]           rvalid_o,
  output logic [DW-1:0]             rdata_o,
  output logic                      busy_o,
  output logic                      mem_wea,
  output logic [3:0]                mem_en,
  output logic [AW-1:0]             mem_addr,
  output logic [DW-1:0]             mem_din,
  input  logic [DW-1:0]             mem_dout
);

  localparam int unsigned IW = $clog2(NREQ);

  state_e          r_state;
  state_e          w_state_nxt;
  logic            r_we;
  logic [3:0]      r_be;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  // Captured requester index doubles as last_grant for the round-robin search.
  logic [IW-1:0]   r_idx;

  logic [NREQ-1:0] w_idx_oh;
  logic [NREQ-1:0] w_prog_mask;
  logic [NREQ-1:0] w_elig;
  logic            w_arb;
  logic            w_valid;
  logic            w_take;
  logic [IW-1:0]   w_win;

  always_comb begin
    w_idx_oh        = '0;
    w_idx_oh[r_idx] = 1'b1;
    w_prog_mask     = '1;
    if (prog) begin
      w_prog_mask           = '0;
      w_prog_mask[REQ_UART] = 1'b1;
    end
    // The requester granted this cycle still holds req_i; it must not win again.
    w_elig = req_i & w_prog_mask & ((r_state == StAccess) ? ~w_idx_oh : '1);
  end

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .eligible_i   (w_elig),
    .last_grant_i (r_idx),
    .valid_o      (w_valid),
    .index_o      (w_win)
  );

  // A read ACCESS is always followed by RDATA, so no arbitration happens there.
  assign w_arb  = (r_state != StAccess) || r_we;
  assign w_take = w_arb && w_valid;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   w_state_nxt = w_take ? StAccess : StIdle;
      StAccess: begin
        if (!r_we) w_state_nxt = StRdata;
        else       w_state_nxt = w_take ? StAccess : StIdle;
      end
      StRdata:  w_state_nxt = w_take ? StAccess : StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    rdata_o  = '0;
    mem_wea  = 1'b0;
    mem_en   = 4'b0000;
    unique case (r_state)
      StAccess: begin
        gnt_o   = w_idx_oh;
        mem_wea = r_we;
        mem_en  = r_we ? r_be : 4'b1111;
      end
      StRdata: begin
        rvalid_o = w_idx_oh;
        rdata_o  = mem_dout;
      end
      default: ;
    endcase
  end

  assign busy_o   = (r_state != StIdle);
  assign mem_addr = r_addr;
  assign mem_din  = r_wdata;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_we    <= 1'b0;
      r_be    <= 4'b0000;
      r_addr  <= '0;
      r_wdata <= '0;
      r_idx   <= IW'(NREQ - 1);
    end else if (w_take) begin
      r_we   <= we_i[w_win];
      r_be   <= be_i[w_win];
      r_addr <= addr_i[w_win];
      // mem_din keeps the last write data across reads.
      if (we_i[w_win]) r_wdata <= wdata_i[w_win];
      r_idx  <= w_win;
    end
  end

endmodule
